// File: rtl/aes_uart_block_bridge.sv
// aes_uart_block_bridge
//   UART front end for the AES datapath. Received 8N1 bytes are packed into
//   BLOCK_BYTES-wide blocks (first byte in the MSBs) and offered on a
//   valid/ready handshake. Result blocks of RSP_BYTES are serialised back onto
//   the line, MSB byte first, LSB bit first.
// Ports
//   clk, reset                 rising-edge clock, asynchronous active-high reset
//   uart_rx / uart_tx          serial in / out, idle high
//   blk_valid/blk_data/blk_ready   inbound block handshake
//   rsp_valid/rsp_data/rsp_ready   outbound result handshake
//   frames_received            mirror of blk_valid
//   uart_tx_ready              mirror of rsp_ready
//   frame_err, overrun         sticky error flags, cleared by reset only
module aes_uart_block_bridge #(
   parameter int CLK_DIV      = 868,
   parameter int BLOCK_BYTES  = 16,
   parameter int RSP_BYTES    = 16,
   parameter int TIMEOUT_BITS = 20
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     uart_rx,
   output logic                     uart_tx,
   output logic                     blk_valid,
   output logic [8*BLOCK_BYTES-1:0] blk_data,
   input  logic                     blk_ready,
   input  logic                     rsp_valid,
   input  logic [8*RSP_BYTES-1:0]   rsp_data,
   output logic                     rsp_ready,
   output logic                     frames_received,
   output logic                     uart_tx_ready,
   output logic                     frame_err,
   output logic                     overrun
);
   localparam int CW     = $clog2(CLK_DIV);
   localparam int BW     = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1;
   localparam int TW     = (RSP_BYTES > 1) ? $clog2(RSP_BYTES) : 1;
   localparam int TO_CYC = TIMEOUT_BITS * CLK_DIV;
   localparam int OW     = $clog2(TO_CYC + 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);
   localparam logic [OW-1:0] TO_LAST   = OW'(TO_CYC - 1);
   localparam logic [BW-1:0] BLK_LAST  = BW'(BLOCK_BYTES - 1);
   localparam logic [TW-1:0] RSP_LAST  = TW'(RSP_BYTES - 1);

   typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
   typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;

   logic                     rx_meta_q, rx_sync_q, rx_prev_q;
   rx_state_t                rx_state_q, rx_state_d;
   logic [CW-1:0]            rx_cnt_q, rx_cnt_d;
   logic [2:0]               rx_bit_q, rx_bit_d;
   logic [7:0]               rx_shift_q, rx_shift_d;
   logic [BW-1:0]            byte_cnt_q, byte_cnt_d;
   logic [OW-1:0]            to_cnt_q, to_cnt_d;
   logic                     blk_valid_q, blk_valid_d;
   logic [8*BLOCK_BYTES-1:0] blk_data_q, blk_data_d;
   logic                     frame_err_q, frame_err_d;
   logic                     overrun_q, overrun_d;

   tx_state_t                tx_state_q, tx_state_d;
   logic [CW-1:0]            tx_cnt_q, tx_cnt_d;
   logic [2:0]               tx_bit_q, tx_bit_d;
   logic [7:0]               tx_byte_q, tx_byte_d;
   logic [8*RSP_BYTES-1:0]   tx_shift_q, tx_shift_d;
   logic [TW-1:0]            tx_idx_q, tx_idx_d;
   logic                     tx_q, tx_d;
   logic                     rsp_ready_q, rsp_ready_d;

   // Receive FSM, byte packing, handshake, timeout and sticky error flags
   always_comb begin
      rx_state_d  = rx_state_q;
      rx_cnt_d    = rx_cnt_q;
      rx_bit_d    = rx_bit_q;
      rx_shift_d  = rx_shift_q;
      byte_cnt_d  = byte_cnt_q;
      to_cnt_d    = to_cnt_q;
      blk_data_d  = blk_data_q;
      frame_err_d = frame_err_q;
      overrun_d   = overrun_q;
      if (blk_valid_q && blk_ready) begin
         blk_valid_d = 1'b0;
      end else begin
         blk_valid_d = blk_valid_q;
      end
      case (rx_state_q)
         R_IDLE: begin
            rx_cnt_d = '0;
            if (rx_prev_q && !rx_sync_q) begin
               rx_state_d = R_START;
               to_cnt_d   = '0;
            end else if (byte_cnt_q != '0) begin
               // A stalled partial block is silently abandoned
               if (to_cnt_q == TO_LAST) begin
                  byte_cnt_d = '0;
                  to_cnt_d   = '0;
               end else begin
                  to_cnt_d = to_cnt_q + OW'(1);
               end
            end else begin
               to_cnt_d = '0;
            end
         end
         R_START: begin
            if (rx_cnt_q == HALF_LAST) begin
               rx_cnt_d = '0;
               rx_bit_d = 3'd0;
               if (rx_sync_q) begin
                  rx_state_d = R_IDLE;
               end else begin
                  rx_state_d = R_DATA;
               end
            end else begin
               rx_cnt_d = rx_cnt_q + CW'(1);
            end
         end
         R_DATA: begin
            if (rx_cnt_q == BIT_LAST) begin
               rx_cnt_d   = '0;
               rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
               if (rx_bit_q == 3'd7) begin
                  rx_state_d = R_STOP;
               end else begin
                  rx_bit_d = rx_bit_q + 3'd1;
               end
            end else begin
               rx_cnt_d = rx_cnt_q + CW'(1);
            end
         end
         R_STOP: begin
            if (rx_cnt_q == BIT_LAST) begin
               rx_cnt_d   = '0;
               rx_state_d = R_IDLE;
               if (!rx_sync_q) begin
                  frame_err_d = 1'b1;
               end else if (blk_valid_q) begin
                  overrun_d = 1'b1;
               end else begin
                  for (int k = 0; k < BLOCK_BYTES; k++) begin
                     blk_data_d[8*(BLOCK_BYTES-k)-1 -: 8] =
                        (byte_cnt_q == BW'(k)) ? rx_shift_q : blk_data_q[8*(BLOCK_BYTES-k)-1 -: 8];
                  end
                  if (byte_cnt_q == BLK_LAST) begin
                     byte_cnt_d  = '0;
                     blk_valid_d = 1'b1;
                  end else begin
                     byte_cnt_d = byte_cnt_q + BW'(1);
                  end
               end
            end else begin
               rx_cnt_d = rx_cnt_q + CW'(1);
            end
         end
         default: begin
            rx_state_d = R_IDLE;
         end
      endcase
   end

   // Transmit FSM: start bit, 8 data bits LSB first, stop bit, per byte
   always_comb begin
      tx_state_d  = tx_state_q;
      tx_cnt_d    = tx_cnt_q;
      tx_bit_d    = tx_bit_q;
      tx_byte_d   = tx_byte_q;
      tx_shift_d  = tx_shift_q;
      tx_idx_d    = tx_idx_q;
      tx_d        = tx_q;
      rsp_ready_d = rsp_ready_q;
      case (tx_state_q)
         T_IDLE: begin
            tx_d        = 1'b1;
            rsp_ready_d = 1'b1;
            tx_cnt_d    = '0;
            if (rsp_valid && rsp_ready_q) begin
               tx_byte_d   = rsp_data[8*RSP_BYTES-1 -: 8];
               tx_shift_d  = rsp_data << 4'd8;
               tx_idx_d    = '0;
               tx_d        = 1'b0;
               rsp_ready_d = 1'b0;
               tx_state_d  = T_START;
            end else begin
               tx_state_d = T_IDLE;
            end
         end
         T_START: begin
            if (tx_cnt_q == BIT_LAST) begin
               tx_cnt_d   = '0;
               tx_bit_d   = 3'd0;
               tx_d       = tx_byte_q[0];
               tx_byte_d  = {1'b0, tx_byte_q[7:1]};
               tx_state_d = T_DATA;
            end else begin
               tx_cnt_d = tx_cnt_q + CW'(1);
            end
         end
         T_DATA: begin
            if (tx_cnt_q == BIT_LAST) begin
               tx_cnt_d = '0;
               if (tx_bit_q == 3'd7) begin
                  tx_d       = 1'b1;
                  tx_state_d = T_STOP;
               end else begin
                  tx_bit_d  = tx_bit_q + 3'd1;
                  tx_d      = tx_byte_q[0];
                  tx_byte_d = {1'b0, tx_byte_q[7:1]};
               end
            end else begin
               tx_cnt_d = tx_cnt_q + CW'(1);
            end
         end
         T_STOP: begin
            if (tx_cnt_q == BIT_LAST) begin
               tx_cnt_d = '0;
               if (tx_idx_q == RSP_LAST) begin
                  tx_d        = 1'b1;
                  rsp_ready_d = 1'b1;
                  tx_state_d  = T_IDLE;
               end else begin
                  // Next byte starts immediately, no idle gap
                  tx_idx_d   = tx_idx_q + TW'(1);
                  tx_byte_d  = tx_shift_q[8*RSP_BYTES-1 -: 8];
                  tx_shift_d = tx_shift_q << 4'd8;
                  tx_d       = 1'b0;
                  tx_state_d = T_START;
               end
            end else begin
               tx_cnt_d = tx_cnt_q + CW'(1);
            end
         end
         default: begin
            tx_state_d = T_IDLE;
         end
      endcase
   end

   // State registers; the rx synchroniser resets to the idle line level
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_meta_q   <= 1'b1;
         rx_sync_q   <= 1'b1;
         rx_prev_q   <= 1'b1;
         rx_state_q  <= R_IDLE;
         rx_cnt_q    <= '0;
         rx_bit_q    <= 3'd0;
         rx_shift_q  <= 8'h00;
         byte_cnt_q  <= '0;
         to_cnt_q    <= '0;
         blk_valid_q <= 1'b0;
         blk_data_q  <= '0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
         tx_state_q  <= T_IDLE;
         tx_cnt_q    <= '0;
         tx_bit_q    <= 3'd0;
         tx_byte_q   <= 8'h00;
         tx_shift_q  <= '0;
         tx_idx_q    <= '0;
         tx_q        <= 1'b1;
         rsp_ready_q <= 1'b1;
      end else begin
         rx_meta_q   <= uart_rx;
         rx_sync_q   <= rx_meta_q;
         rx_prev_q   <= rx_sync_q;
         rx_state_q  <= rx_state_d;
         rx_cnt_q    <= rx_cnt_d;
         rx_bit_q    <= rx_bit_d;
         rx_shift_q  <= rx_shift_d;
         byte_cnt_q  <= byte_cnt_d;
         to_cnt_q    <= to_cnt_d;
         blk_valid_q <= blk_valid_d;
         blk_data_q  <= blk_data_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
         tx_state_q  <= tx_state_d;
         tx_cnt_q    <= tx_cnt_d;
         tx_bit_q    <= tx_bit_d;
         tx_byte_q   <= tx_byte_d;
         tx_shift_q  <= tx_shift_d;
         tx_idx_q    <= tx_idx_d;
         tx_q        <= tx_d;
         rsp_ready_q <= rsp_ready_d;
      end
   end

   assign uart_tx         = tx_q;
   assign blk_valid       = blk_valid_q;
   assign blk_data        = blk_data_q;
   assign rsp_ready       = rsp_ready_q;
   assign frames_received = blk_valid_q;
   assign uart_tx_ready   = rsp_ready_q;
   assign frame_err       = frame_err_q;
   assign overrun         = overrun_q;
endmodule

// File: tb/tb_aes_uart_block_bridge.sv
// Directed bench for aes_uart_block_bridge with CLK_DIV=8, 4-byte blocks and
// 2-byte results. Inputs change and outputs are sampled on the falling edge.
module tb_aes_uart_block_bridge;
   localparam int CLK_DIV = 8;
   localparam int BB      = 4;
   localparam int RB      = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          uart_rx;
   logic          uart_tx;
   logic          blk_valid;
   logic [8*BB-1:0] blk_data;
   logic          blk_ready;
   logic          rsp_valid;
   logic [8*RB-1:0] rsp_data;
   logic          rsp_ready;
   logic          frames_received;
   logic          uart_tx_ready;
   logic          frame_err;
   logic          overrun;

   int n_cmp = 0;
   int n_bad = 0;

   aes_uart_block_bridge #(
      .CLK_DIV(CLK_DIV), .BLOCK_BYTES(BB), .RSP_BYTES(RB), .TIMEOUT_BITS(20)
   ) dut (
      .clk(clk), .reset(reset), .uart_rx(uart_rx), .uart_tx(uart_tx),
      .blk_valid(blk_valid), .blk_data(blk_data), .blk_ready(blk_ready),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
      .frames_received(frames_received), .uart_tx_ready(uart_tx_ready),
      .frame_err(frame_err), .overrun(overrun)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drives one 8N1 frame with a selectable stop level, then 12 idle cycles
   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      @(negedge clk) uart_rx = 1'b0;
      repeat (CLK_DIV) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         repeat (CLK_DIV) @(negedge clk);
      end
      uart_rx = stop_bit;
      repeat (CLK_DIV) @(negedge clk);
      uart_rx = 1'b1;
      repeat (12) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] word;
      logic [7:0]  byte_v;
      logic [19:0] frame;
      int          low_cnt;

      reset = 1'b1; uart_rx = 1'b1; blk_ready = 1'b0; rsp_valid = 1'b0; rsp_data = 16'h0000;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      check_val("rst_uart_tx", 64'(uart_tx), 64'd1);
      check_val("rst_blk_valid", 64'(blk_valid), 64'd0);
      check_val("rst_blk_data", 64'(blk_data), 64'd0);
      check_val("rst_rsp_ready", 64'(rsp_ready), 64'd1);
      check_val("rst_frames_received", 64'(frames_received), 64'd0);
      check_val("rst_uart_tx_ready", 64'(uart_tx_ready), 64'd1);
      check_val("rst_flags", 64'({frame_err, overrun}), 64'd0);

      // 1: basic block with back-pressure
      send_byte(8'hDE, 1'b1); send_byte(8'hAD, 1'b1);
      send_byte(8'hBE, 1'b1); send_byte(8'hEF, 1'b1);
      check_val("t1_valid", 64'(blk_valid), 64'd1);
      check_val("t1_data", 64'(blk_data), 64'hDEADBEEF);
      repeat (10) @(negedge clk);
      check_val("t1_hold_valid", 64'(blk_valid), 64'd1);
      check_val("t1_hold_data", 64'(blk_data), 64'hDEADBEEF);
      blk_ready = 1'b1;
      @(negedge clk);
      check_val("t1_drop", 64'(blk_valid), 64'd0);
      blk_ready = 1'b0;

      // 2: transmit A55A, check every bit centre and ready-low duration
      word = 16'hA55A;
      for (int b = 0; b < RB; b++) begin
         byte_v = word[15-8*b -: 8];
         frame[10*b] = 1'b0;
         for (int i = 0; i < 8; i++) frame[10*b+1+i] = byte_v[i];
         frame[10*b+9] = 1'b1;
      end
      check_val("t2_ready_before", 64'(rsp_ready), 64'd1);
      rsp_valid = 1'b1; rsp_data = word;
      low_cnt = 0;
      for (int n = 1; n <= 170; n++) begin
         @(negedge clk);
         if (n == 1) rsp_valid = 1'b0;
         if (!rsp_ready) low_cnt++;
         if (n >= 5 && ((n - 5) % CLK_DIV) == 0 && ((n - 5) / CLK_DIV) < 20)
            check_val($sformatf("t2_tx_bit%0d", (n - 5) / CLK_DIV), 64'(uart_tx),
                      64'(frame[(n - 5) / CLK_DIV]));
      end
      check_val("t2_ready_low_cycles", 64'(low_cnt), 64'd160);
      check_val("t2_ready_after", 64'(rsp_ready), 64'd1);
      check_val("t2_tx_idle", 64'(uart_tx), 64'd1);

      // 3: partial block timed out, then a full block
      send_byte(8'h01, 1'b1); send_byte(8'h02, 1'b1); send_byte(8'h03, 1'b1);
      repeat (200) @(negedge clk);
      check_val("t3_no_valid_partial", 64'(blk_valid), 64'd0);
      send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1);
      send_byte(8'h33, 1'b1); send_byte(8'h44, 1'b1);
      check_val("t3_valid", 64'(blk_valid), 64'd1);
      check_val("t3_data", 64'(blk_data), 64'h11223344);
      check_val("t3_flags", 64'({frame_err, overrun}), 64'd0);
      blk_ready = 1'b1;
      @(negedge clk);
      blk_ready = 1'b0;
      check_val("t3_drop", 64'(blk_valid), 64'd0);

      // 4: bad stop bit is discarded and flagged
      send_byte(8'h55, 1'b0);
      check_val("t4_frame_err", 64'(frame_err), 64'd1);
      check_val("t4_no_valid", 64'(blk_valid), 64'd0);
      send_byte(8'hCA, 1'b1); send_byte(8'hFE, 1'b1);
      send_byte(8'hBA, 1'b1); send_byte(8'hBE, 1'b1);
      check_val("t4_valid", 64'(blk_valid), 64'd1);
      check_val("t4_data", 64'(blk_data), 64'hCAFEBABE);
      check_val("t4_overrun_clear", 64'(overrun), 64'd0);

      // 5: extra byte while block pending
      send_byte(8'h77, 1'b1);
      check_val("t5_overrun", 64'(overrun), 64'd1);
      check_val("t5_data_kept", 64'(blk_data), 64'hCAFEBABE);
      check_val("t5_valid_kept", 64'(blk_valid), 64'd1);
      check_val("t5_frame_err_sticky", 64'(frame_err), 64'd1);

      // 6: reset during an rx frame and a tx byte
      @(negedge clk);
      rsp_valid = 1'b1; rsp_data = 16'h00FF;
      @(negedge clk);
      rsp_valid = 1'b0;
      uart_rx = 1'b0;
      repeat (20) @(negedge clk);
      check_val("t6_tx_busy_low", 64'(uart_tx), 64'd0);
      check_val("t6_ready_busy", 64'(rsp_ready), 64'd0);
      reset = 1'b1;
      #1;
      check_val("t6_rst_uart_tx", 64'(uart_tx), 64'd1);
      check_val("t6_rst_blk_valid", 64'(blk_valid), 64'd0);
      check_val("t6_rst_rsp_ready", 64'(rsp_ready), 64'd1);
      check_val("t6_rst_flags", 64'({frame_err, overrun}), 64'd0);
      check_val("t6_rst_blk_data", 64'(blk_data), 64'd0);
      uart_rx = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (10) @(negedge clk);
      check_val("t6_tx_idle_after", 64'(uart_tx), 64'd1);
      send_byte(8'h12, 1'b1); send_byte(8'h34, 1'b1);
      send_byte(8'h56, 1'b1); send_byte(8'h78, 1'b1);
      check_val("t6_valid", 64'(blk_valid), 64'd1);
      check_val("t6_data", 64'(blk_data), 64'h12345678);
      check_val("t6_flags", 64'({frame_err, overrun}), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
